// File: rtl/mem_ctrl_if.sv
// Pipeline-side (IF/MEM) and byte-wide RAM-side signals of the memory controller.
// slave = the controller, master = pipeline plus RAM.
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        stallreq_from_if;
  logic        stallreq_from_mem;

  // Handshake: a request is held high with its address/size/data stable until
  // the matching one-cycle done pulse; the request may drop in the cycle after.
  // A fetch may additionally be withdrawn early (flush); a data access may not.
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_size, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_a, ram_dout, ram_wr,
           stallreq_from_if, stallreq_from_mem
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_size, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_a, ram_dout, ram_wr,
           stallreq_from_if, stallreq_from_mem
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch vs data access and serialises each access
// into one-byte cycles on a synchronous-read RAM port. MEM has priority over IF.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  mem_ctrl_if.slave   bus,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_e;

  state_e      state_q, state_d;
  logic        src_q, src_d;          // 1 = data access owns the RAM, 0 = fetch
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] base_q, base_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [2:0]  req_n;
  logic [1:0]  wr_idx, rd_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      src_q       <= 1'b0;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= 32'd0;
      buf_q       <= 32'd0;
      ram_a_q     <= 32'd0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    buf_d       = buf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    req_n  = (bus.mem_size == 2'd0) ? 3'd1 : (bus.mem_size == 2'd1) ? 3'd2 : 3'd4;
    wr_idx = cnt_q[1:0] + 2'd1;
    rd_idx = cnt_q[1:0] - 2'd1;

    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          src_d   = 1'b1;
          base_d  = bus.mem_addr;
          n_d     = req_n;
          cnt_d   = 3'd0;
          buf_d   = 32'd0;
          ram_a_d = bus.mem_addr;
          if (bus.mem_we) begin
            state_d    = WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata[7:0];
          end else begin
            state_d = RD;
          end
        end else if (bus.if_req) begin
          src_d   = 1'b0;
          base_d  = bus.if_addr;
          n_d     = 3'd4;
          cnt_d   = 3'd0;
          buf_d   = 32'd0;
          ram_a_d = bus.if_addr;
          state_d = RD;
        end
      end
      RD: begin
        if (!src_q && !bus.if_req) begin
          state_d = IDLE;
        end else begin
          // cnt is the index of the address on ram_a; its byte returns a cycle later.
          if (cnt_q != 3'd0) buf_d[{rd_idx, 3'b000} +: 8] = bus.ram_din;
          if (cnt_q == n_q) begin
            state_d = DONE;
            if (src_q) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = buf_d;
            end else begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_d < n_q) ram_a_d = base_q + {29'd0, cnt_d};
          end
        end
      end
      WR: begin
        if (cnt_q + 3'd1 < n_q) begin
          cnt_d      = cnt_q + 3'd1;
          ram_a_d    = base_q + {29'd0, cnt_d};
          ram_dout_d = bus.mem_wdata[{wr_idx, 3'b000} +: 8];
          ram_wr_d   = 1'b1;
        end else begin
          state_d    = DONE;
          mem_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_a             = ram_a_q;
  assign bus.ram_dout          = ram_dout_q;
  assign bus.ram_wr            = ram_wr_q;
  assign bus.if_done           = if_done_q;
  assign bus.mem_done          = mem_done_q;
  assign bus.if_data           = if_data_q;
  assign bus.mem_rdata         = mem_rdata_q;
  assign bus.stallreq_from_if  = bus.if_req & ~if_done_q;
  assign bus.stallreq_from_mem = bus.mem_req & ~mem_done_q;
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 1 KiB byte RAM model (address bits [9:0]).
module tb_mem_ctrl;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [7:0] ram [0:1023];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read RAM model
  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_a[9:0]] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_a[9:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_addr(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, bus.ram_a, e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_size  = 2'd0;
    bus.mem_wdata = 32'd0;
  endtask

  task automatic mem_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wdata);
    bus.mem_req   = 1'b1;
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_size  = size;
    bus.mem_wdata = wdata;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"},     {30'd0, dbg_state}, 32'd0);
    check_eq({tag, "_ram_a"},     bus.ram_a, 32'd0);
    check_eq({tag, "_ram_dout"},  {24'd0, bus.ram_dout}, 32'd0);
    check_eq({tag, "_ram_wr"},    {31'd0, bus.ram_wr}, 32'd0);
    check_eq({tag, "_if_done"},   {31'd0, bus.if_done}, 32'd0);
    check_eq({tag, "_mem_done"},  {31'd0, bus.mem_done}, 32'd0);
    check_eq({tag, "_if_data"},   bus.if_data, 32'd0);
    check_eq({tag, "_mem_rdata"}, bus.mem_rdata, 32'd0);
    check_eq({tag, "_stall_if"},  {31'd0, bus.stallreq_from_if}, 32'd0);
    check_eq({tag, "_stall_mem"}, {31'd0, bus.stallreq_from_mem}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    ram[10'h202] = 8'h5A;
    ram[10'h010] = 8'h80;
    ram[10'h000] = 8'h93; ram[10'h001] = 8'h00; ram[10'h002] = 8'h10; ram[10'h003] = 8'h00;
    ram[10'h3FE] = 8'hA1; ram[10'h3FF] = 8'hB2;
    idle_inputs();
    rst = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check_reset_outputs("reset");
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // word load at 0x100
    mem_access(1'b0, 32'h100, 2'd2, 32'd0);
    for (int a = 0; a < 4; a++) exp_q.push_back(32'h100 + a);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("ld_stall_c%0d", c), {31'd0, bus.stallreq_from_mem}, (c < 6) ? 32'd1 : 32'd0);
      check_eq($sformatf("ld_done_c%0d", c), {31'd0, bus.mem_done}, (c == 6) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 4) check_addr($sformatf("ld_ram_a_c%0d", c));
      if (c >= 1 && c <= 5) check_eq($sformatf("ld_ram_wr_c%0d", c), {31'd0, bus.ram_wr}, 32'd0);
      if (c == 6) check_eq("ld_rdata", bus.mem_rdata, 32'h44332211);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // halfword store at 0x200
    mem_access(1'b1, 32'h200, 2'd1, 32'hDEADBEEF);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("st_wr_c%0d", c), {31'd0, bus.ram_wr}, (c == 1 || c == 2) ? 32'd1 : 32'd0);
      check_eq($sformatf("st_done_c%0d", c), {31'd0, bus.mem_done}, (c == 3) ? 32'd1 : 32'd0);
      if (c == 1) begin
        check_eq("st_a0", bus.ram_a, 32'h200);
        check_eq("st_d0", {24'd0, bus.ram_dout}, 32'hEF);
      end
      if (c == 2) begin
        check_eq("st_a1", bus.ram_a, 32'h201);
        check_eq("st_d1", {24'd0, bus.ram_dout}, 32'hBE);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    check_eq("st_ram200", {24'd0, ram[10'h200]}, 32'hEF);
    check_eq("st_ram201", {24'd0, ram[10'h201]}, 32'hBE);
    check_eq("st_ram202", {24'd0, ram[10'h202]}, 32'h5A);

    // arbitration: byte load beats a simultaneous fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    mem_access(1'b0, 32'h10, 2'd0, 32'd0);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      check_eq($sformatf("arb_mdone_c%0d", c), {31'd0, bus.mem_done}, (c == 3) ? 32'd1 : 32'd0);
      check_eq($sformatf("arb_idone_c%0d", c), {31'd0, bus.if_done}, (c == 10) ? 32'd1 : 32'd0);
      check_eq($sformatf("arb_stall_if_c%0d", c), {31'd0, bus.stallreq_from_if}, (c < 10) ? 32'd1 : 32'd0);
      if (c == 1) check_eq("arb_ld_a", bus.ram_a, 32'h10);
      if (c == 3) check_eq("arb_ld_rdata", bus.mem_rdata, 32'h00000080);
      if (c >= 5 && c <= 8) check_eq($sformatf("arb_if_a_c%0d", c), bus.ram_a, 32'(c - 5));
      if (c == 10) check_eq("arb_if_data", bus.if_data, 32'h00100093);
      next_cycle();
      if (c == 3) begin
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
      end
    end
    idle_inputs();
    next_cycle();

    // fetch abort with a pending byte load
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 2) begin
        bus.if_req = 1'b0;
        mem_access(1'b0, 32'h10, 2'd0, 32'd0);
      end
      @(negedge clk);
      check_eq($sformatf("ab_idone_c%0d", c), {31'd0, bus.if_done}, 32'd0);
      check_eq($sformatf("ab_wr_c%0d", c), {31'd0, bus.ram_wr}, 32'd0);
      if (c == 3) check_eq("ab_state_idle", {30'd0, dbg_state}, 32'd0);
      if (c == 4) begin
        check_eq("ab_state_rd", {30'd0, dbg_state}, 32'd1);
        check_eq("ab_ld_a", bus.ram_a, 32'h10);
      end
      check_eq($sformatf("ab_mdone_c%0d", c), {31'd0, bus.mem_done}, (c == 6) ? 32'd1 : 32'd0);
      if (c == 6) check_eq("ab_rdata", bus.mem_rdata, 32'h00000080);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // wrap-around word load
    mem_access(1'b0, 32'hFFFFFFFE, 2'd2, 32'd0);
    exp_q.push_back(32'hFFFFFFFE);
    exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00000001);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) check_addr($sformatf("wrap_a_c%0d", c));
      if (c == 6) begin
        check_eq("wrap_done", {31'd0, bus.mem_done}, 32'd1);
        check_eq("wrap_rdata", bus.mem_rdata, 32'h0093B2A1);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // asynchronous reset in the middle of a word store
    mem_access(1'b1, 32'h300, 2'd2, 32'h01020304);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rst_wr_before", {31'd0, bus.ram_wr}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_wr_async", {31'd0, bus.ram_wr}, 32'd0);
    check_eq("rst_state_async", {30'd0, dbg_state}, 32'd0);
    idle_inputs();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");
    next_cycle();
    @(negedge clk);
    check_eq("post_rst_state_hold", {30'd0, dbg_state}, 32'd0);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
